// File: rtl/fp_accel_pkg.sv
// Shared sizing for the fingerprint accelerator: vector/bus widths, word count
// per fingerprint and the number of bits kept from the final bus word.
package fp_accel_pkg;

  localparam int VECTOR_WIDTH = 920;
  localparam int BUS_WIDTH    = 128;

  function automatic int sub_vector_no(input int vw, input int bw);
    return (vw + bw - 1) / bw;
  endfunction

  // Bits of the final word that land inside the fingerprint.
  function automatic int last_keep_width(input int vw, input int bw);
    return vw - (sub_vector_no(vw, bw) - 1) * bw;
  endfunction

  localparam int SUB_VECTOR_NO = sub_vector_no(VECTOR_WIDTH, BUS_WIDTH);
  localparam int LAST_KEEP     = last_keep_width(VECTOR_WIDTH, BUS_WIDTH);
  localparam int CNT_WIDTH     = $clog2(VECTOR_WIDTH);
  localparam int WCNT_WIDTH    = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;

endpackage

// File: rtl/subvec_assembler_if.sv
// Upstream word stream plus downstream fingerprint port of subvec_assembler.
// o_ProtoErr exists only when SUBVEC_ASM_CHECK_EN is defined.
interface subvec_assembler_if;
  import fp_accel_pkg::*;

  // Both sides: a transfer happens on a rising edge where valid && ready;
  // valid must not wait on ready, and payload is held while valid && !ready.
  logic [BUS_WIDTH-1:0]    up_SubVector;
  logic                    up_Valid;
  logic [CNT_WIDTH-1:0]    up_Cnt;
  logic                    up_CntNew;
  logic                    up_Ready;
  logic [VECTOR_WIDTH-1:0] dn_Vector;
  logic [CNT_WIDTH-1:0]    dn_Cnt;
  logic                    dn_Valid;
  logic                    dn_Ready;
`ifdef SUBVEC_ASM_CHECK_EN
  logic                    o_ProtoErr;
`endif

  modport master (
    output up_SubVector, up_Valid, up_Cnt, up_CntNew, dn_Ready,
    input  up_Ready, dn_Vector, dn_Cnt, dn_Valid
`ifdef SUBVEC_ASM_CHECK_EN
    , input o_ProtoErr
`endif
  );

  modport slave (
    input  up_SubVector, up_Valid, up_Cnt, up_CntNew, dn_Ready,
    output up_Ready, dn_Vector, dn_Cnt, dn_Valid
`ifdef SUBVEC_ASM_CHECK_EN
    , output o_ProtoErr
`endif
  );

endinterface

// File: rtl/subvec_assembler_slot.sv
// One ping-pong slot: per-word vector storage, weight register and full flag.
// The final word keeps only the bits that fall inside the fingerprint.
module subvec_slot
  import fp_accel_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [WCNT_WIDTH-1:0]   wr_idx_i,
  input  logic [BUS_WIDTH-1:0]    wr_data_i,
  input  logic                    cnt_ld_i,
  input  logic [CNT_WIDTH-1:0]    cnt_i,
  input  logic                    full_set_i,
  input  logic                    full_clr_i,
  output logic [VECTOR_WIDTH-1:0] vec_o,
  output logic [CNT_WIDTH-1:0]    cnt_o,
  output logic                    full_o
);

  logic [LAST_KEEP-1:0] last_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 full_q;

  for (genvar k = 0; k < SUB_VECTOR_NO - 1; k++) begin : g_word
    logic [BUS_WIDTH-1:0] word_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
      end else if (wr_en_i && (wr_idx_i == WCNT_WIDTH'(k))) begin
        word_q <= wr_data_i;
      end
    end
    assign vec_o[k*BUS_WIDTH +: BUS_WIDTH] = word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (wr_en_i && (wr_idx_i == WCNT_WIDTH'(SUB_VECTOR_NO - 1))) begin
        last_q <= wr_data_i[LAST_KEEP-1:0];
      end
      if (cnt_ld_i) begin
        cnt_q <= cnt_i;
      end
      // Set and clear never target the same slot in one cycle.
      if (full_set_i) begin
        full_q <= 1'b1;
      end else if (full_clr_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign vec_o[VECTOR_WIDTH-1 -: LAST_KEEP] = last_q;
  assign cnt_o  = cnt_q;
  assign full_o = full_q;

endmodule

// File: rtl/subvec_assembler.sv
// Reassembles BUS_WIDTH sub-vectors into VECTOR_WIDTH fingerprints via two
// ping-pong slots. Optional sticky protocol checker under SUBVEC_ASM_CHECK_EN.
module subvec_assembler
  import fp_accel_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  subvec_assembler_if.slave  bus
);

  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [WCNT_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic [1:0]              slot_full;
  logic [VECTOR_WIDTH-1:0] slot_vec [2];
  logic [CNT_WIDTH-1:0]    slot_cnt [2];

  logic up_ready, dn_valid, beat, last_word, complete, xfer;

  // up_Ready depends only on registered state, never on dn_Ready.
  assign up_ready  = !slot_full[wr_ptr_q];
  assign dn_valid  = slot_full[rd_ptr_q];
  assign beat      = bus.up_Valid && up_ready;
  assign last_word = (wcnt_q == WCNT_WIDTH'(SUB_VECTOR_NO - 1));
  assign complete  = beat && last_word;
  assign xfer      = dn_valid && bus.dn_Ready;

  always_comb begin
    wcnt_d   = wcnt_q;
    wr_ptr_d = wr_ptr_q ^ complete;
    rd_ptr_d = rd_ptr_q ^ xfer;
    if (beat) begin
      wcnt_d = last_word ? '0 : wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wcnt_q   <= wcnt_d;
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    localparam logic SEL = 1'(s);
    subvec_slot u_slot (
      .clk        (clk),
      .rst_n      (rstn),
      .wr_en_i    (beat && (wr_ptr_q == SEL)),
      .wr_idx_i   (wcnt_q),
      .wr_data_i  (bus.up_SubVector),
      .cnt_ld_i   (complete && (wr_ptr_q == SEL)),
      .cnt_i      (bus.up_Cnt),
      .full_set_i (complete && (wr_ptr_q == SEL)),
      .full_clr_i (xfer && (rd_ptr_q == SEL)),
      .vec_o      (slot_vec[s]),
      .cnt_o      (slot_cnt[s]),
      .full_o     (slot_full[s])
    );
  end

  assign bus.up_Ready  = up_ready;
  assign bus.dn_Valid  = dn_valid;
  assign bus.dn_Vector = slot_vec[rd_ptr_q];
  assign bus.dn_Cnt    = slot_cnt[rd_ptr_q];

`ifdef SUBVEC_ASM_CHECK_EN
  logic proto_err_q;

  // Sticky: up_CntNew must mark exactly the word-counter's final word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      proto_err_q <= 1'b0;
    end else if (beat && (bus.up_CntNew != last_word)) begin
      proto_err_q <= 1'b1;
    end
  end

  assign bus.o_ProtoErr = proto_err_q;
`else
  logic unused_cnt_new;
  assign unused_cnt_new = bus.up_CntNew;
`endif

endmodule

// File: tb/tb_subvec_assembler.sv
// Self-checking bench for subvec_assembler: random words against a queue of
// fingerprints assembled by plain concatenation/truncation.
module tb_subvec_assembler;
  import fp_accel_pkg::*;

  localparam int VW  = VECTOR_WIDTH;
  localparam int BW  = BUS_WIDTH;
  localparam int SUB = SUB_VECTOR_NO;
  localparam int CW  = CNT_WIDTH;

  typedef logic [BW-1:0] word_t;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  subvec_assembler_if bus ();

  subvec_assembler dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int rcv_cnt = 0;

  logic [VW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  word_t         words [SUB];

  // reference model: a fingerprint is its words laid end to end, cut to VW bits
  function automatic logic [VW-1:0] assemble(input word_t w [SUB]);
    logic [SUB*BW-1:0] flat;
    for (int k = 0; k < SUB; k++) flat[k*BW +: BW] = w[k];
    return flat[VW-1:0];
  endfunction

  // scoreboard
  logic [VW-1:0] sb_vec;
  logic [CW-1:0] sb_cnt;
  always @(negedge clk) begin
    if (rstn && bus.dn_Valid && bus.dn_Ready) begin
      checks++;
      rcv_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got dn_Cnt=%0d lo=%h, want nothing queued",
                 bus.dn_Cnt, bus.dn_Vector[127:0]);
      end else begin
        sb_vec = exp_q.pop_front();
        sb_cnt = exp_cnt_q.pop_front();
        if (bus.dn_Vector !== sb_vec || bus.dn_Cnt !== sb_cnt) begin
          errors++;
          $display("FAIL sb_data: got cnt=%0d lo=%h hi=%h, want cnt=%0d lo=%h hi=%h",
                   bus.dn_Cnt, bus.dn_Vector[127:0], bus.dn_Vector[VW-1 -: 128],
                   sb_cnt, sb_vec[127:0], sb_vec[VW-1 -: 128]);
        end
      end
    end
  end

  // driver tasks
  task automatic fill_random();
    for (int k = 0; k < SUB; k++) words[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send_beat(input word_t d, input logic [CW-1:0] c, input logic cn);
    int guard;
    bus.up_SubVector = d;
    bus.up_Cnt       = c;
    bus.up_CntNew    = cn;
    bus.up_Valid     = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.up_Ready && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    if (!bus.up_Ready) begin
      checks++;
      errors++;
      $display("FAIL up_ready_timeout: got up_Ready=0 after %0d cycles, want 1", guard);
    end
    @(posedge clk);
    #1;
    bus.up_Valid  = 1'b0;
    bus.up_CntNew = 1'b0;
  endtask

  task automatic send_vector(input logic [CW-1:0] c, input int cn_pos);
    exp_q.push_back(assemble(words));
    exp_cnt_q.push_back(c);
    for (int k = 0; k < SUB; k++) send_beat(words[k], c, (k == cn_pos - 1));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d vectors still expected, want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    #1 rstn = 1'b0;
    #1;
    checks += 3;
    if (bus.dn_Valid !== 1'b0) begin errors++; $display("FAIL rst_dn_valid: got %b want 0", bus.dn_Valid); end
    if (bus.dn_Vector !== '0) begin errors++; $display("FAIL rst_dn_vector: got lo=%h want 0", bus.dn_Vector[127:0]); end
    if (bus.dn_Cnt !== '0) begin errors++; $display("FAIL rst_dn_cnt: got %0d want 0", bus.dn_Cnt); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.up_Ready !== 1'b1) begin errors++; $display("FAIL rst_up_ready: got %b want 1", bus.up_Ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_ones();
    bus.dn_Ready = 1'b1;
    for (int k = 0; k < SUB; k++) words[k] = '1;
    send_vector(CW'(VW), SUB);
    checks += 3;
    if (bus.dn_Valid !== 1'b1) begin errors++; $display("FAIL ones_latency: got dn_Valid=%b want 1", bus.dn_Valid); end
    if (bus.dn_Vector !== {VW{1'b1}}) begin errors++; $display("FAIL ones_vector: got hi=%h want all ones", bus.dn_Vector[VW-1 -: 128]); end
    if (bus.dn_Cnt !== CW'(VW)) begin errors++; $display("FAIL ones_cnt: got %0d want %0d", bus.dn_Cnt, VW); end
    wait_drain(20);
  endtask

  task automatic test_last_word();
    word_t lw;
    bus.dn_Ready = 1'b1;
    fill_random();
    lw = {16'hFFFF, 104'h0, 8'hAB};
    words[SUB-1] = lw;
    send_vector(CW'($urandom_range(0, VW)), SUB);
    checks++;
    if (bus.dn_Vector[VW-1 -: 24] !== 24'h0000AB) begin
      errors++;
      $display("FAIL last_word_trunc: got %h want 0000ab", bus.dn_Vector[VW-1 -: 24]);
    end
    wait_drain(20);
  endtask

  task automatic test_stall();
    int rcv0;
    rcv0 = rcv_cnt;
    bus.dn_Ready = 1'b0;
    fill_random();
    send_vector(CW'($urandom_range(0, VW)), SUB);
    checks++;
    if (bus.up_Ready !== 1'b1) begin errors++; $display("FAIL stall_one_full: got up_Ready=%b want 1", bus.up_Ready); end
    fill_random();
    send_vector(CW'($urandom_range(0, VW)), SUB);
    checks += 2;
    if (bus.up_Ready !== 1'b0) begin errors++; $display("FAIL stall_both_full: got up_Ready=%b want 0", bus.up_Ready); end
    if (bus.dn_Valid !== 1'b1) begin errors++; $display("FAIL stall_dn_valid: got %b want 1", bus.dn_Valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.dn_Vector !== exp_q[0] || bus.dn_Cnt !== exp_cnt_q[0]) begin
        errors++;
        $display("FAIL stall_hold: got cnt=%0d lo=%h want cnt=%0d lo=%h",
                 bus.dn_Cnt, bus.dn_Vector[127:0], exp_cnt_q[0], exp_q[0][127:0]);
      end
    end
    @(posedge clk);
    #1;
    fork
      begin
        fill_random();
        send_vector(CW'($urandom_range(0, VW)), SUB);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.dn_Ready = 1'b1;
      end
    join
    wait_drain(100);
    checks++;
    if (rcv_cnt - rcv0 !== 3) begin errors++; $display("FAIL stall_count: got %0d vectors want 3", rcv_cnt - rcv0); end
  endtask

  task automatic test_reset_mid();
    int rcv0;
    bus.dn_Ready = 1'b1;
    fill_random();
    for (int k = 0; k < 4; k++) send_beat(words[k], '0, 1'b0);
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.dn_Valid !== 1'b0 || bus.dn_Vector !== '0) begin
      errors++;
      $display("FAIL mid_rst_clear: got dn_Valid=%b lo=%h want 0 0", bus.dn_Valid, bus.dn_Vector[127:0]);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rcv0 = rcv_cnt;
    fill_random();
    send_vector(CW'($urandom_range(0, VW)), SUB);
    checks++;
    if (bus.dn_Valid !== 1'b1 || bus.dn_Vector[BW-1:0] !== words[0]) begin
      errors++;
      $display("FAIL mid_rst_word0: got valid=%b w0=%h want 1 %h", bus.dn_Valid, bus.dn_Vector[BW-1:0], words[0]);
    end
    wait_drain(20);
    repeat (4) @(negedge clk);
    checks++;
    if (rcv_cnt - rcv0 !== 1) begin errors++; $display("FAIL mid_rst_count: got %0d vectors want 1", rcv_cnt - rcv0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int stalls;
    int pulses[$];
    stalls = 0;
    bus.dn_Ready = 1'b1;
    fork
      begin
        for (int v = 0; v < 4; v++) begin
          fill_random();
          send_vector(CW'($urandom_range(0, VW)), SUB);
        end
      end
      begin
        for (int i = 0; i < 4 * SUB + 4; i++) begin
          @(negedge clk);
          if (bus.up_Valid && !bus.up_Ready) stalls++;
          if (bus.dn_Valid) pulses.push_back(i);
        end
      end
    join
    checks += 2;
    if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d stall cycles want 0", stalls); end
    if (pulses.size() !== 4) begin errors++; $display("FAIL b2b_pulses: got %0d dn_Valid cycles want 4", pulses.size()); end
    for (int i = 1; i < pulses.size(); i++) begin
      checks++;
      if (pulses[i] - pulses[i-1] !== SUB) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles want %0d", pulses[i] - pulses[i-1], SUB);
      end
    end
    wait_drain(20);
  endtask

`ifdef SUBVEC_ASM_CHECK_EN
  task automatic test_proto_err();
    logic [CW-1:0] c;
    do_reset();
    checks++;
    if (bus.o_ProtoErr !== 1'b0) begin errors++; $display("FAIL proto_reset: got %b want 0", bus.o_ProtoErr); end
    bus.dn_Ready = 1'b1;
    fill_random();
    c = CW'($urandom_range(0, VW));
    exp_q.push_back(assemble(words));
    exp_cnt_q.push_back(c);
    for (int k = 0; k < SUB; k++) begin
      send_beat(words[k], c, (k == 4));
      if (k == 3) begin
        checks++;
        if (bus.o_ProtoErr !== 1'b0) begin errors++; $display("FAIL proto_early: got %b want 0", bus.o_ProtoErr); end
      end
      if (k == 4) begin
        checks++;
        if (bus.o_ProtoErr !== 1'b1) begin errors++; $display("FAIL proto_set: got %b want 1", bus.o_ProtoErr); end
      end
    end
    wait_drain(20);
    checks++;
    if (bus.o_ProtoErr !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b want 1", bus.o_ProtoErr); end
    do_reset();
    checks++;
    if (bus.o_ProtoErr !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b want 0", bus.o_ProtoErr); end
  endtask
`endif

  initial begin
    bus.up_SubVector = '0;
    bus.up_Valid     = 1'b0;
    bus.up_Cnt       = '0;
    bus.up_CntNew    = 1'b0;
    bus.dn_Ready     = 1'b0;
    test_reset();
    test_all_ones();
    test_last_word();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef SUBVEC_ASM_CHECK_EN
    test_proto_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: got no completion by 200000, want finish earlier");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
